// File: rtl/flit_sink_pkg.sv
// rtl/flit_sink_pkg.sv - shared flit type codes, FSM states and error bit indices for flit_sink
package flit_sink_pkg;

    localparam int FLIT_TYPE_W = 2;
    localparam int FLIT_DATA_W = 64;
    localparam int FLIT_VCH_W  = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        TYPE_NONE = 2'd0,
        TYPE_HEAD = 2'd1,
        TYPE_DATA = 2'd2,
        TYPE_TAIL = 2'd3
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } sink_state_e;

    // sticky error bit positions
    localparam int ERR_ORPHAN      = 0;  // DATA/TAIL seen outside a packet
    localparam int ERR_NESTED_HEAD = 1;  // HEAD arrived inside an open packet
    localparam int ERR_VCH_CHANGE  = 2;  // VC differs from the one latched at HEAD
    localparam int ERR_PROTO       = 3;  // NONE type flit or payload length overflow
    localparam int ERR_W           = 4;

endpackage

// File: rtl/flit_popcount.sv
// rtl/flit_popcount.sv - combinational population count of a DATA_W vector
module flit_popcount #(
    parameter int DATA_W = 64,
    parameter int OUT_W  = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] din,
    output logic [OUT_W-1:0]  cnt
);

    // sum of set bits; synthesis folds this into an adder tree
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cnt = cnt + OUT_W'(din[i]);
        end
    end

endmodule

// File: rtl/flit_sink.sv
// rtl/flit_sink.sv - flit stream endpoint: framing parser, statistics, error flags; FLIT_SINK_TOGGLE_EN adds payload toggle counting
module flit_sink
    import flit_sink_pkg::*;
#(
    parameter int TYPE_W = FLIT_TYPE_W,
    parameter int DATA_W = FLIT_DATA_W,
    parameter int VCH_W  = FLIT_VCH_W,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic [TYPE_W+DATA_W-1:0] idata,
    input  logic                     ivalid,
    input  logic [VCH_W-1:0]         ivch,
    input  logic                     clr,
    output logic                     busy,
    output logic                     pkt_done,
    output logic [LEN_W-1:0]         last_len,
    output logic [VCH_W-1:0]         last_vch,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic [CNT_W-1:0]         flit_cnt,
    output logic [CNT_W-1:0]         tog_cnt,
    output logic [ERR_W-1:0]         err
);

    logic [TYPE_W-1:0] ftype;
    logic [DATA_W-1:0] payload;
    logic              is_head;
    logic              is_data;
    logic              is_tail;
    logic              is_none;

    assign ftype   = idata[TYPE_W+DATA_W-1 -: TYPE_W];
    assign payload = idata[DATA_W-1:0];
    assign is_head = (ftype == TYPE_W'(TYPE_HEAD));
    assign is_data = (ftype == TYPE_W'(TYPE_DATA));
    assign is_tail = (ftype == TYPE_W'(TYPE_TAIL));
    assign is_none = (ftype == TYPE_W'(TYPE_NONE));

    sink_state_e       state_q,    state_d;
    logic [LEN_W-1:0]  len_q,      len_d;
    logic [VCH_W-1:0]  vch_q,      vch_d;
    logic              pkt_done_q, pkt_done_d;
    logic [LEN_W-1:0]  last_len_q, last_len_d;
    logic [VCH_W-1:0]  last_vch_q, last_vch_d;
    logic [CNT_W-1:0]  pkt_cnt_q,  pkt_cnt_d;
    logic [CNT_W-1:0]  flit_cnt_q, flit_cnt_d;
    logic [ERR_W-1:0]  err_q,      err_d;
    logic [ERR_W-1:0]  err_set;
    logic              pkt_inc;

    // framing FSM next state: packet tracking, completion capture and error detection
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        vch_d      = vch_q;
        pkt_done_d = 1'b0;
        last_len_d = last_len_q;
        last_vch_d = last_vch_q;
        err_set    = '0;
        pkt_inc    = 1'b0;
        if (ivalid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_head) begin
                        state_d = ST_BODY;
                        vch_d   = ivch;
                        len_d   = '0;
                    end else if (is_none) begin
                        err_set[ERR_PROTO] = 1'b1;
                    end else begin
                        // DATA or TAIL with no open packet is dropped
                        err_set[ERR_ORPHAN] = 1'b1;
                    end
                end
                ST_BODY: begin
                    if (ivch != vch_q) begin
                        err_set[ERR_VCH_CHANGE] = 1'b1;
                    end
                    if (is_head) begin
                        // abandon the open packet uncounted and restart on the new VC
                        err_set[ERR_NESTED_HEAD] = 1'b1;
                        vch_d = ivch;
                        len_d = '0;
                    end else if (is_data) begin
                        if (len_q == '1) begin
                            err_set[ERR_PROTO] = 1'b1;
                        end else begin
                            len_d = len_q + 1'b1;
                        end
                    end else if (is_tail) begin
                        pkt_done_d = 1'b1;
                        last_len_d = len_q;
                        last_vch_d = vch_q;
                        pkt_inc    = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        err_set[ERR_PROTO] = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // statistics counters: saturating, with clr taking priority over any increment
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        flit_cnt_d = flit_cnt_q;
        err_d      = err_q | err_set;
        if (pkt_inc && (pkt_cnt_q != '1)) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
        if (ivalid && (flit_cnt_q != '1)) begin
            flit_cnt_d = flit_cnt_q + 1'b1;
        end
        if (clr) begin
            pkt_cnt_d  = '0;
            flit_cnt_d = '0;
            err_d      = '0;
        end
    end

    // state and statistics registers
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            vch_q      <= '0;
            pkt_done_q <= 1'b0;
            last_len_q <= '0;
            last_vch_q <= '0;
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            vch_q      <= vch_d;
            pkt_done_q <= pkt_done_d;
            last_len_q <= last_len_d;
            last_vch_q <= last_vch_d;
            pkt_cnt_q  <= pkt_cnt_d;
            flit_cnt_q <= flit_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef FLIT_SINK_TOGGLE_EN
    localparam int PC_W = $clog2(DATA_W) + 1;

    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] prev_q,    prev_d;
    logic [CNT_W-1:0]  tog_cnt_q, tog_cnt_d;
    logic [CNT_W:0]    tog_sum;

    flit_popcount #(
        .DATA_W (DATA_W),
        .OUT_W  (PC_W)
    ) u_popcount (
        .din (payload ^ prev_q),
        .cnt (pc)
    );

    // toggle accumulator: Hamming distance to the previous payload, saturating, clr wins
    always_comb begin
        prev_d    = prev_q;
        tog_cnt_d = tog_cnt_q;
        tog_sum   = {1'b0, tog_cnt_q} + (CNT_W+1)'(pc);
        if (ivalid) begin
            prev_d    = payload;
            tog_cnt_d = tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];
        end
        if (clr) begin
            tog_cnt_d = '0;
        end
    end

    // toggle registers; the previous payload survives clr so the next distance stays meaningful
    always_ff @(posedge clk) begin
        if (rst_) begin
            prev_q    <= '0;
            tog_cnt_q <= '0;
        end else begin
            prev_q    <= prev_d;
            tog_cnt_q <= tog_cnt_d;
        end
    end

    assign tog_cnt = tog_cnt_q;
`else
    wire unused_payload = ^payload;

    assign tog_cnt = '0;
`endif

    assign busy     = (state_q == ST_BODY);
    assign pkt_done = pkt_done_q;
    assign last_len = last_len_q;
    assign last_vch = last_vch_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign flit_cnt = flit_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_flit_sink.sv
// tb/tb_flit_sink.sv - directed self-checking bench for flit_sink
module tb_flit_sink;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_HEAD = 2'd1;
    localparam logic [1:0] T_DATA = 2'd2;
    localparam logic [1:0] T_TAIL = 2'd3;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic [65:0] idata = '0;
    logic        ivalid = 1'b0;
    logic [1:0]  ivch = '0;
    logic        clr = 1'b0;
    logic        busy;
    logic        pkt_done;
    logic [7:0]  last_len;
    logic [1:0]  last_vch;
    logic [31:0] pkt_cnt;
    logic [31:0] flit_cnt;
    logic [31:0] tog_cnt;
    logic [3:0]  err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flit_sink dut (
        .clk      (clk),
        .rst_     (rst_),
        .idata    (idata),
        .ivalid   (ivalid),
        .ivch     (ivch),
        .clr      (clr),
        .busy     (busy),
        .pkt_done (pkt_done),
        .last_len (last_len),
        .last_vch (last_vch),
        .pkt_cnt  (pkt_cnt),
        .flit_cnt (flit_cnt),
        .tog_cnt  (tog_cnt),
        .err      (err)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // inputs change on the falling edge; registered outputs are read there too
    task automatic drive(input logic [1:0] t, input logic [1:0] v, input logic [63:0] p);
        @(negedge clk);
        ivalid = 1'b1;
        ivch   = v;
        idata  = {t, p};
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        ivalid = 1'b0;
        clr    = 1'b0;
        idata  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ivalid = 1'b0;
        clr    = 1'b0;
        rst_   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        ivalid = 1'b0;
        clr    = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic packet(input logic [1:0] v, input int ndata);
        drive(T_HEAD, v, 64'd0);
        for (int i = 0; i < ndata; i++) drive(T_DATA, v, 64'd0);
        drive(T_TAIL, v, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"},     64'(busy),     64'd0);
        check_val({tag, "_pkt_done"}, 64'(pkt_done), 64'd0);
        check_val({tag, "_last_len"}, 64'(last_len), 64'd0);
        check_val({tag, "_last_vch"}, 64'(last_vch), 64'd0);
        check_val({tag, "_pkt_cnt"},  64'(pkt_cnt),  64'd0);
        check_val({tag, "_flit_cnt"}, 64'(flit_cnt), 64'd0);
        check_val({tag, "_tog_cnt"},  64'(tog_cnt),  64'd0);
        check_val({tag, "_err"},      64'(err),      64'd0);
    endtask

    initial begin
        logic [63:0] tog_exp1;
        logic [63:0] tog_exp2;
`ifdef FLIT_SINK_TOGGLE_EN
        tog_exp1 = 64'd64;
        tog_exp2 = 64'd122;
`else
        tog_exp1 = 64'd0;
        tog_exp2 = 64'd0;
`endif

        do_reset();
        check_all_zero("reset");

        // single packet, 20 DATA on vch 1
        drive(T_HEAD, 2'd1, 64'd0);
        drive(T_DATA, 2'd1, 64'd0);
        check_val("norm_busy", 64'(busy), 64'd1);
        for (int i = 1; i < 20; i++) drive(T_DATA, 2'd1, 64'd0);
        drive(T_TAIL, 2'd1, 64'd0);
        check_val("norm_done_before", 64'(pkt_done), 64'd0);
        idle_cyc();
        check_val("norm_pkt_done", 64'(pkt_done), 64'd1);
        check_val("norm_last_len", 64'(last_len), 64'd20);
        check_val("norm_last_vch", 64'(last_vch), 64'd1);
        check_val("norm_pkt_cnt",  64'(pkt_cnt),  64'd1);
        check_val("norm_flit_cnt", 64'(flit_cnt), 64'd22);
        check_val("norm_err",      64'(err),      64'd0);
        check_val("norm_busy_end", 64'(busy),     64'd0);
        idle_cyc();
        check_val("norm_done_pulse", 64'(pkt_done), 64'd0);

        // gapped traffic after a statistics clear
        do_clr();
        check_val("clr_pkt_cnt",  64'(pkt_cnt),  64'd0);
        check_val("clr_flit_cnt", 64'(flit_cnt), 64'd0);
        check_val("clr_last_len", 64'(last_len), 64'd20);
        for (int p = 0; p < 10; p++) begin
            packet(2'd3, 20);
            idle_cyc();
            check_val("gap_busy", 64'(busy), 64'd0);
            for (int g = 1; g < 7; g++) idle_cyc();
        end
        check_val("gap_pkt_cnt",  64'(pkt_cnt),  64'd10);
        check_val("gap_flit_cnt", 64'(flit_cnt), 64'd220);
        check_val("gap_err",      64'(err),      64'd0);

        // orphan DATA, then nested HEAD
        do_clr();
        drive(T_DATA, 2'd0, 64'd0);
        idle_cyc();
        check_val("orph_err",     64'(err),     64'b0001);
        check_val("orph_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check_val("orph_busy",    64'(busy),    64'd0);
        drive(T_HEAD, 2'd0, 64'd0);
        for (int i = 0; i < 3; i++) drive(T_DATA, 2'd0, 64'd0);
        drive(T_HEAD, 2'd0, 64'd0);
        for (int i = 0; i < 2; i++) drive(T_DATA, 2'd0, 64'd0);
        drive(T_TAIL, 2'd0, 64'd0);
        idle_cyc();
        check_val("nest_err",      64'(err),      64'b0011);
        check_val("nest_last_len", 64'(last_len), 64'd2);
        check_val("nest_pkt_cnt",  64'(pkt_cnt),  64'd1);
        check_val("nest_flit_cnt", 64'(flit_cnt), 64'd9);

        // VC change mid-packet
        do_clr();
        drive(T_HEAD, 2'd0, 64'd0);
        drive(T_DATA, 2'd2, 64'd0);
        drive(T_TAIL, 2'd0, 64'd0);
        idle_cyc();
        check_val("vch_err",      64'(err),      64'b0100);
        check_val("vch_last_len", 64'(last_len), 64'd1);
        check_val("vch_last_vch", 64'(last_vch), 64'd0);
        check_val("vch_pkt_done", 64'(pkt_done), 64'd1);

        // NONE type in IDLE
        do_clr();
        drive(T_NONE, 2'd0, 64'd0);
        idle_cyc();
        check_val("none_err",      64'(err),      64'b1000);
        check_val("none_flit_cnt", 64'(flit_cnt), 64'd1);

        // length saturation: 256 DATA flits, last one overflows
        do_clr();
        packet(2'd1, 256);
        idle_cyc();
        check_val("ovf_err",      64'(err),      64'b1000);
        check_val("ovf_last_len", 64'(last_len), 64'd255);
        check_val("ovf_pkt_cnt",  64'(pkt_cnt),  64'd1);
        check_val("ovf_flit_cnt", 64'(flit_cnt), 64'd258);

        // reset mid-packet
        drive(T_HEAD, 2'd3, 64'd0);
        for (int i = 0; i < 5; i++) drive(T_DATA, 2'd3, 64'd0);
        @(negedge clk);
        ivalid = 1'b0;
        rst_   = 1'b1;
        @(negedge clk);
        rst_ = 1'b0;
        check_all_zero("rstmid");
        idle_cyc();
        check_val("rstmid_no_done", 64'(pkt_done), 64'd0);

        // toggle accumulation from a zero previous payload
        drive(T_HEAD, 2'd0, 64'd0);
        drive(T_DATA, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("tog_first", 64'(tog_cnt), 64'd0);
        drive(T_TAIL, 2'd0, 64'h0000_0000_0000_003F);
        check_val("tog_64", 64'(tog_cnt), tog_exp1);
        idle_cyc();
        check_val("tog_122", 64'(tog_cnt), tog_exp2);

        // clr coincident with TAIL
        do_reset();
        drive(T_HEAD, 2'd2, 64'd0);
        for (int i = 0; i < 3; i++) drive(T_DATA, 2'd2, 64'd0);
        drive(T_TAIL, 2'd2, 64'd0);
        clr = 1'b1;
        idle_cyc();
        check_val("clrtail_pkt_cnt",  64'(pkt_cnt),  64'd0);
        check_val("clrtail_flit_cnt", 64'(flit_cnt), 64'd0);
        check_val("clrtail_last_len", 64'(last_len), 64'd3);
        check_val("clrtail_last_vch", 64'(last_vch), 64'd2);
        check_val("clrtail_pkt_done", 64'(pkt_done), 64'd1);
        check_val("clrtail_busy",     64'(busy),     64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flit_sink.md
Name: flit_sink

Overview:
- Receive-side endpoint for the router flit stream produced by a mux output port (data/valid/vch triple).
- Parses HEAD/DATA/TAIL framing, counts packets and payload flits, and flags protocol violations.
- Accumulates payload bit-toggle counts as a switching-activity proxy for energy characterization runs.
- Sits after the mux/router output in characterization benches and at NoC ejection ports.

Parameters:
- TYPE_W, 2, flit type field width (NONE=0, HEAD=1, DATA=2, TAIL=3).
- DATA_W, 64, flit payload width below the type field.
- VCH_W, 2, virtual channel id width.
- LEN_W, 8, payload-length counter width.
- CNT_W, 32, packet/flit/toggle counter width.

Ports:
- clk  in  1  clock.
- rst_  in  1  synchronous reset, active-high (asserted = 1).
- idata  in  TYPE_W+DATA_W  flit; type in the MSBs, payload below.
- ivalid  in  1  flit valid.
- ivch  in  VCH_W  flit virtual channel.
- clr  in  1  synchronous clear of statistics counters only.
- busy  out  1  packet in progress (state BODY).
- pkt_done  out  1  one-cycle pulse, cycle after TAIL accepted.
- last_len  out  LEN_W  DATA-flit count of the last completed packet.
- last_vch  out  VCH_W  VC of the last completed packet.
- pkt_cnt  out  CNT_W  completed packets.
- flit_cnt  out  CNT_W  all valid flits accepted.
- tog_cnt  out  CNT_W  accumulated payload Hamming distance.
- err  out  4  sticky error bits: [0] orphan DATA/TAIL, [1] HEAD inside packet, [2] VC change mid-packet, [3] NONE type or length overflow.

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset state: all outputs 0; FSM in IDLE; length counter 0; previous-payload register 0.
- Always ready; no backpressure. Every cycle with ivalid=1 is one accepted flit; flit_cnt increments.
- FSM IDLE:
  - HEAD: latch ivch; clear length counter; go to BODY.
  - DATA/TAIL: set err[0]; drop the flit; stay in IDLE.
  - NONE: set err[3]; stay in IDLE.
- FSM BODY:
  - DATA: length counter +1; saturates at 2^LEN_W-1. An increment attempted at saturation sets err[3].
  - TAIL: next cycle pkt_done=1, last_len=count, last_vch=latched VC, pkt_cnt+1; go to IDLE.
  - HEAD: set err[1]; abandon the current packet (not counted); restart as a new packet with the new VC; stay in BODY.
  - NONE: set err[3]; ignore the flit.
- Any valid flit in BODY whose ivch differs from the latched VC sets err[2]. The flit is still processed by type.
- ivalid=0: no state change. Gaps inside a packet are legal.
- Toggle count: on each valid flit, tog_cnt += popcount(payload XOR previous payload), then the previous payload register is updated. Registered, so visible 1 cycle after the flit. Counter saturates at all-ones.
- Counter rules:
  - All counters saturate; none wrap.
  - clr zeroes pkt_cnt, flit_cnt, tog_cnt and err. It does not touch the FSM, length counter, last_* or the previous-payload register.
  - If clr and an increment occur in the same cycle, clr wins.
- rst_ asserted mid-packet: immediately returns to IDLE, all state cleared, no pkt_done. rst_ has priority over clr.
- Latency: pkt_done and counter updates are visible the cycle after the triggering flit.

Optional Feature:
- Macro FLIT_SINK_TOGGLE_EN.
- Defined: toggle accumulator and previous-payload register are present, as described above.
- Undefined: no popcount logic and no previous-payload register; tog_cnt is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package/defines holds:
  - flit type codes TYPE_NONE/HEAD/DATA/TAIL and TYPE_W;
  - default DATA_W, VCH_W;
  - FSM state encodings IDLE=0, BODY=1;
  - err bit index constants.
- One sub-module: flit_popcount (combinational popcount of a DATA_W vector; output width $clog2(DATA_W)+1). Instantiated only under FLIT_SINK_TOGGLE_EN.

Test Plan:
- Normal packet: HEAD(vch=1), 20 DATA, TAIL on consecutive cycles → one pkt_done pulse; last_len=20, last_vch=1, pkt_cnt=1, flit_cnt=22, err=0.
- Gapped traffic: 10 packets of 20 DATA flits, 7 idle cycles between packets → pkt_cnt=10, flit_cnt=220, busy low during the gaps.
- Orphan and overlap:
  - DATA in IDLE → err=0001, pkt_cnt=0.
  - Then HEAD, 3 DATA, HEAD, 2 DATA, TAIL → err gains bit1; last_len=2; pkt_cnt=1.
- VC change: HEAD vch=0, DATA vch=2, TAIL vch=0 → err[2]=1; packet still completes with last_len=1.
- Toggle (macro defined): payloads 0, all-ones, 0x0000_0000_0000_003F → tog_cnt=64, then 64+58=122. With macro undefined → tog_cnt stays 0.
- Reset/clear: rst_=1 after 5 DATA flits → busy=0, no pkt_done, all outputs 0; clr in the same cycle as a TAIL → pkt_cnt=0 but last_len is updated.
